// File: rtl/neuron_sigmoid_pipe.sv
// neuron_sigmoid_pipe
// -------------------
// Output stage of the four-input neuron. Takes the neuron's negated weighted sum
// (neg_sum = -(w.x + bias)) in signed Q8.8 and produces sigmoid(z), z = -neg_sum,
// through a four-segment piecewise-linear approximation. There are three pipeline
// stages, a class bit and a wrapping count of delivered results.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      neg_sum is valid
//   in_ready   out  1      the pipeline can take a sample this cycle
//   neg_sum    in   IN_W   signed Q8.8 negated weighted sum
//   out_valid  out  1      y and y_class are valid
//   out_ready  in   1      the consumer takes y this cycle
//   y          out  8      unsigned Q0.8 sigmoid value
//   y_class    out  1      y >= THRESH
//   res_cnt    out  CNT_W  number of delivered results, wraps
//
// Handshake: a transfer happens on a port in every cycle where valid and ready are
// both high. The source holds its data while valid is high and ready is low. All
// three stages advance together when the output register is empty or is being
// drained (adv). Bubbles travel down the pipe as valid=0 and are not collapsed.
module neuron_sigmoid_pipe #(
    parameter int IN_W   = 16,
    parameter int THRESH = 128,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  neg_sum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              y,
    output logic                    y_class,
    output logic [CNT_W-1:0]        res_cnt
);

    localparam logic signed [IN_W-1:0] MIN_NEG = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic [IN_W-2:0] A_SEG1 = (IN_W-1)'(256);   // |z| < 1.0
    localparam logic [IN_W-2:0] A_SEG2 = (IN_W-1)'(608);   // |z| < 2.375
    localparam logic [IN_W-2:0] A_SEG3 = (IN_W-1)'(1280);  // |z| < 5.0
    localparam logic [7:0]      THRESH_V = 8'(THRESH);

    logic adv;

    // Stage 1 registers: sign of z and |z|.
    logic            s1_valid;
    logic            s1_sgn;
    logic [IN_W-2:0] s1_a;

    // Stage 2 registers: positive-half sigmoid value f (Q0.8, up to 256) and sign.
    logic            s2_valid;
    logic            s2_sgn;
    logic [8:0]      s2_f;

    // Stage 1 combinational terms
    logic            sgn_d;
    logic [IN_W-2:0] a_d;
    logic [IN_W-2:0] neg_mag;

    // Stage 2 / 3 combinational terms
    logic [8:0]      f_d;
    logic [8:0]      v_d;
    logic [7:0]      y_d;
    logic            class_d;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // The low IN_W-1 bits of -neg_sum; that is |z| whenever z >= 0 and z is representable.
    assign neg_mag = -neg_sum[IN_W-2:0];

    // z = -neg_sum. The most negative input would overflow, so it saturates to the
    // largest positive z. A positive neg_sum means z < 0 and |z| = neg_sum.
    always_comb begin
        sgn_d = 1'b0;
        a_d   = neg_mag;
        if (neg_sum == MIN_NEG) begin
            a_d = '1;
        end else if (!neg_sum[IN_W-1] && (neg_sum != '0)) begin
            sgn_d = 1'b1;
            a_d   = neg_sum[IN_W-2:0];
        end
    end

    // Piecewise-linear segments on |z|. The slice in each segment is the truncating
    // shift; the bounds of the segment keep the slice narrow enough for 9-bit f.
    always_comb begin
        f_d = 9'd256;
        if (s1_a < A_SEG1) begin
            f_d = 9'd128 + {3'b000, s1_a[7:2]};
        end else if (s1_a < A_SEG2) begin
            f_d = 9'd160 + {2'b00, s1_a[9:3]};
        end else if (s1_a < A_SEG3) begin
            f_d = 9'd216 + {3'b000, s1_a[10:5]};
        end
    end

    // Sigmoid symmetry: sigmoid(-z) = 1 - sigmoid(z). 1.0 (256) clamps to 255.
    always_comb begin
        v_d     = s2_sgn ? (9'd256 - s2_f) : s2_f;
        y_d     = v_d[8] ? 8'hFF : v_d[7:0];
        class_d = (y_d >= THRESH_V);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sgn    <= 1'b0;
            s1_a      <= '0;
            s2_valid  <= 1'b0;
            s2_sgn    <= 1'b0;
            s2_f      <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            y_class   <= 1'b0;
            res_cnt   <= '0;
        end else begin
            if (adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sgn <= sgn_d;
                    s1_a   <= a_d;
                end
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sgn <= s1_sgn;
                    s2_f   <= f_d;
                end
                out_valid <= s2_valid;
                // y keeps the last delivered value while a bubble occupies the output.
                if (s2_valid) begin
                    y       <= y_d;
                    y_class <= class_d;
                end
            end
            if (out_valid && out_ready) begin
                res_cnt <= res_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_neuron_sigmoid_pipe.sv
// Bench for neuron_sigmoid_pipe. The counter is built 4 bits wide so that it wraps
// within a short run.
module tb_neuron_sigmoid_pipe;

    localparam int CW = 4;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] neg_sum;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         y;
    logic               y_class;
    logic [CW-1:0]      res_cnt;

    neuron_sigmoid_pipe #(.IN_W(16), .THRESH(128), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .neg_sum   (neg_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_class   (y_class),
        .res_cnt   (res_cnt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [8:0]    exp_q[$];    // {y_class, y}
    int            cyc_q[$];    // cycle in which each sample was accepted
    logic [CW-1:0] exp_cnt;
    int            checks   = 0;
    int            failures = 0;
    bit            lat_chk  = 1'b0;
    bit            rand_rdy = 1'b0;

    // Reference: sigmoid approximation straight from the segment table, in integers.
    function automatic logic [8:0] ref_model(input logic signed [15:0] ns);
        int z, a, f, v, yy;
        z = -int'(ns);
        if (z > 32767) z = 32767;
        a = (z < 0) ? -z : z;
        if (a < 256)       f = a / 4 + 128;
        else if (a < 608)  f = a / 8 + 160;
        else if (a < 1280) f = a / 32 + 216;
        else               f = 256;
        v  = (z < 0) ? 256 - f : f;
        yy = (v > 255) ? 255 : v;
        return {(yy >= 128), 8'(yy)};
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: samples mid-cycle, so the values seen are the ones the next edge acts on.
    task automatic monitor();
        logic [8:0] e;
        int         c;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
                check("res_cnt", int'(res_cnt), int'(exp_cnt));
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_model(neg_sum));
                    cyc_q.push_back(cyc);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        c = cyc_q.pop_front();
                        check("y", int'(y), int'(e[7:0]));
                        check("y_class", int'(y_class), int'(e[8]));
                        if (lat_chk) check("latency", cyc - c, 3);
                    end
                    exp_cnt = exp_cnt + 1'b1;
                end
            end
        end
    endtask

    task automatic rand_ready();
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called one time unit after a rising edge; returns at the same phase.
    task automatic send(input logic signed [15:0] v);
        int n;
        in_valid = 1'b1;
        neg_sum  = v;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        idle(2);
    endtask

    // ---------------- main sequence ----------------
    logic signed [15:0] dir_tab[12];

    initial begin
        dir_tab = '{16'sd0, -16'sd256, 16'sd256, -16'sd1280, 16'sd1280, -16'sd32768,
                    -16'sd128, -16'sd768, -16'sd608, 16'sd32767, -16'sd1, 16'sd1};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        neg_sum   = '0;
        out_ready = 1'b1;
        exp_cnt   = '0;

        fork
            monitor();
            rand_ready();
        join_none

        // Reset state
        #23;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_y", int'(y), 0);
        check("rst_y_class", int'(y_class), 0);
        check("rst_res_cnt", int'(res_cnt), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed points: single sample with gaps, then back to back, full-rate sink.
        lat_chk = 1'b1;
        send(16'sd0);
        idle(5);
        foreach (dir_tab[i]) send(dir_tab[i]);
        drain();
        lat_chk = 1'b0;

        // Random values and gaps with a randomly stalling consumer.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int r;
            if ($urandom_range(0, 1) == 0) begin
                r = $urandom_range(0, 3000);
                send(16'(r - 1500));
            end else begin
                send(16'($urandom));
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        idle(1);

        // Reset with three samples in flight.
        send(-16'sd100);
        send(16'sd500);
        send(-16'sd2000);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_res_cnt", int'(res_cnt), 0);
        check("midrst_y", int'(y), 0);
        exp_q.delete();
        cyc_q.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(4);
        check("post_rst_out_valid", int'(out_valid), 0);

        // 17 results through a 4-bit counter leaves it at 1.
        lat_chk = 1'b1;
        for (int i = 0; i < 17; i++) send(16'($urandom_range(0, 4000)) - 16'sd2000);
        drain();
        check("cnt_wrap_17", int'(res_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
